// File: rtl/mmio_pkg.sv
// Shared definitions for the lab7 memory-mapped I/O stage: CPU command codes,
// the I/O register address map and the seven-segment digit decoder.
package mmio_pkg;

   typedef enum logic [1:0] {
      MNONE  = 2'b00,
      MREAD  = 2'b01,
      MWRITE = 2'b10
   } mem_cmd_e;

   localparam logic [8:0] ADDR_LED       = 9'h100;
   localparam logic [8:0] ADDR_HEX       = 9'h120;
   localparam logic [8:0] ADDR_SW        = 9'h140;
   localparam logic [8:0] ADDR_SW_STATUS = 9'h141;

   // Active-low segment pattern, bit order g..a, for one hex nibble.
   function automatic logic [6:0] hex7seg(input logic [3:0] nibble);
      logic [6:0] seg;
      case (nibble)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/mmio_bus_unit_sw_debouncer.sv
// Switch input conditioning: two-flop synchroniser followed by a stability
// counter. A candidate value is accepted once it has been seen unchanged for
// DEB_CYCLES consecutive cycles; any bounce restarts the count.
module sw_debouncer #(
   parameter int SW_W       = 8,
   parameter int DEB_CYCLES = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [SW_W-1:0] sw_in,
   output logic [SW_W-1:0] stable,
   output logic            changed
);

   localparam int CNT_W = $clog2(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [SW_W-1:0]  sync1;
   logic [SW_W-1:0]  sync2;
   logic [SW_W-1:0]  cand;
   logic [CNT_W-1:0] cnt;
   logic             settled;

   // Bring the asynchronous switches into the clock domain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= sw_in;
         sync2 <= sync1;
      end
   end

   // The candidate has been stable long enough; changed flags a new value being accepted at the coming edge.
   always_comb begin
      settled = (sync2 == cand) && (cnt == CNT_LAST);
      changed = settled && (cand != stable);
   end

   // Track the candidate, count its stable cycles and commit it once the count completes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cand   <= '0;
         cnt    <= '0;
         stable <= '0;
      end else if (sync2 != cand) begin
         cand <= sync2;
         cnt  <= '0;
      end else if (cnt == CNT_LAST) begin
         stable <= cand;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mmio_bus_unit.sv
// Memory-select and board I/O stage behind the CPU memory interface. Steers
// reads and writes to RAM (addresses below 0x100) or the LED, HEX and switch
// registers, and returns read data with the same one-cycle latency as the RAM.
module mmio_bus_unit
   import mmio_pkg::*;
#(
   parameter int SW_W       = 8,
   parameter int DEB_CYCLES = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [1:0]      mem_cmd,
   input  logic [8:0]      mem_addr,
   input  logic [15:0]     write_data,
   output logic [15:0]     read_data,
   input  logic [15:0]     ram_rdata,
   output logic            ram_write,
   input  logic [SW_W-1:0] sw_in,
   output logic [SW_W-1:0] ledr,
   output logic [6:0]      hex0,
   output logic [6:0]      hex1,
   output logic [6:0]      hex2,
   output logic [6:0]      hex3
);

   logic            is_read;
   logic            is_write;
   logic            sel_ram;
   logic            sel_led;
   logic            sel_hex;
   logic            sel_sw;
   logic            sel_stat;
   logic [15:0]     io_rdata;
   logic [SW_W-1:0] led_q;
   logic [15:0]     hex_q;
   logic            flag_q;
   logic [15:0]     rd_q;
   logic            ram_pend;
   logic [SW_W-1:0] sw_stable;
   logic            sw_changed;

   sw_debouncer #(
      .SW_W       (SW_W),
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debouncer (
      .clk     (clk),
      .reset   (reset),
      .sw_in   (sw_in),
      .stable  (sw_stable),
      .changed (sw_changed)
   );

   // Command and address decode; code 11 falls out as no operation.
   always_comb begin
      is_read  = (mem_cmd == MREAD);
      is_write = (mem_cmd == MWRITE);
      sel_ram  = ~mem_addr[8];
      sel_led  = (mem_addr == ADDR_LED);
      sel_hex  = (mem_addr == ADDR_HEX);
      sel_sw   = (mem_addr == ADDR_SW);
      sel_stat = (mem_addr == ADDR_SW_STATUS);
   end

   // I/O read mux, zero-extended to the bus width; unmapped addresses read 0.
   always_comb begin
      io_rdata = '0;
      if (sel_led) begin
         io_rdata[SW_W-1:0] = led_q;
      end else if (sel_hex) begin
         io_rdata = hex_q;
      end else if (sel_sw) begin
         io_rdata[SW_W-1:0] = sw_stable;
      end else if (sel_stat) begin
         io_rdata[0] = flag_q;
      end
   end

   assign ram_write = is_write && sel_ram;

   // LED and HEX registers update on the edge of the write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_q <= '0;
         hex_q <= '0;
      end else if (is_write) begin
         if (sel_led) begin
            led_q <= write_data[SW_W-1:0];
         end
         if (sel_hex) begin
            hex_q <= write_data;
         end
      end
   end

   // Sticky switch-change flag; a new change on the same edge as a status read keeps it set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flag_q <= 1'b0;
      end else if (sw_changed) begin
         flag_q <= 1'b1;
      end else if (is_read && sel_stat) begin
         flag_q <= 1'b0;
      end
   end

   // Read return: I/O data is captured at the command edge; for RAM only the source is remembered
   // and the RAM's own output is passed through next cycle, then captured so the value holds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q     <= '0;
         ram_pend <= 1'b0;
      end else if (is_read) begin
         if (sel_ram) begin
            ram_pend <= 1'b1;
         end else begin
            rd_q     <= io_rdata;
            ram_pend <= 1'b0;
         end
      end else if (ram_pend) begin
         rd_q     <= ram_rdata;
         ram_pend <= 1'b0;
      end
   end

   assign read_data = ram_pend ? ram_rdata : rd_q;
   assign ledr      = led_q;
   assign hex0      = hex7seg(hex_q[3:0]);
   assign hex1      = hex7seg(hex_q[7:4]);
   assign hex2      = hex7seg(hex_q[11:8]);
   assign hex3      = hex7seg(hex_q[15:12]);

endmodule

// File: tb/tb_mmio_bus_unit.sv
// Self-checking bench for mmio_bus_unit: directed vector table, hand-written
// reset/debounce sequences and a randomized phase against a behavioural model.
module tb_mmio_bus_unit;
   import mmio_pkg::*;

   localparam int SW_W = 8;
   localparam int DEB  = 4;

   logic            clk;
   logic            reset;
   logic [1:0]      mem_cmd;
   logic [8:0]      mem_addr;
   logic [15:0]     write_data;
   logic [15:0]     read_data;
   logic [15:0]     ram_rdata;
   logic            ram_write;
   logic [SW_W-1:0] sw_in;
   logic [SW_W-1:0] ledr;
   logic [6:0]      hex0, hex1, hex2, hex3;

   int checks = 0;
   int errors = 0;

   mmio_bus_unit #(.SW_W(SW_W), .DEB_CYCLES(DEB)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_cmd    (mem_cmd),
      .mem_addr   (mem_addr),
      .write_data (write_data),
      .read_data  (read_data),
      .ram_rdata  (ram_rdata),
      .ram_write  (ram_write),
      .sw_in      (sw_in),
      .ledr       (ledr),
      .hex0       (hex0),
      .hex1       (hex1),
      .hex2       (hex2),
      .hex3       (hex3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] ram_init(int i);
      return 16'(i * 257) ^ 16'h5A3C;
   endfunction

   // Environment RAM with synchronous read, written through the DUT's enable.
   logic [15:0] ram_mem [256];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) ram_mem[i] <= ram_init(i);
         ram_rdata <= '0;
      end else begin
         if (ram_write) ram_mem[mem_addr[7:0]] <= write_data;
         ram_rdata <= ram_mem[mem_addr[7:0]];
      end
   end

   // Reference segment patterns for 0..F, active low g..a.
   logic [6:0] seg7 [16];
   initial seg7 = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Behavioural model state.
   logic [15:0]     m_ram [256];
   logic [SW_W-1:0] m_led;
   logic [15:0]     m_hex;
   logic [SW_W-1:0] m_stable;
   logic            m_flag;
   logic [15:0]     m_rd;
   bit              m_rd_valid;
   bit              m_rd_ram;
   logic [SW_W-1:0] hist [$];

   task automatic clearModel();
      for (int i = 0; i < 256; i++) m_ram[i] = ram_init(i);
      m_led = '0; m_hex = '0; m_stable = '0; m_flag = 1'b0;
      m_rd = '0; m_rd_valid = 1'b1; m_rd_ram = 1'b0;
      hist.delete();
   endtask

   // Model: a switch value is accepted once the last DEB+1 samples, excluding
   // the two still inside the synchroniser, are all equal.
   always @(posedge clk) begin
      logic [15:0] rv;
      bit          eq;
      bit          set;
      if (!reset) begin
         if (mem_cmd == MREAD) begin
            if (mem_addr < 9'h100)               rv = m_ram[mem_addr[7:0]];
            else if (mem_addr == ADDR_LED)       rv = 16'(m_led);
            else if (mem_addr == ADDR_HEX)       rv = m_hex;
            else if (mem_addr == ADDR_SW)        rv = 16'(m_stable);
            else if (mem_addr == ADDR_SW_STATUS) rv = 16'(m_flag);
            else                                 rv = 16'h0000;
            m_rd = rv; m_rd_valid = 1'b1; m_rd_ram = (mem_addr < 9'h100);
         end else if (m_rd_ram) begin
            m_rd_valid = 1'b0;
         end
         hist.push_back(sw_in);
         if (hist.size() > DEB + 3) void'(hist.pop_front());
         set = 1'b0;
         if (hist.size() == DEB + 3) begin
            eq = 1'b1;
            for (int i = 1; i <= DEB; i++) if (hist[i] != hist[0]) eq = 1'b0;
            if (eq && hist[0] != m_stable) begin
               m_stable = hist[0];
               set = 1'b1;
            end
         end
         if (set) m_flag = 1'b1;
         else if (mem_cmd == MREAD && mem_addr == ADDR_SW_STATUS) m_flag = 1'b0;
         if (mem_cmd == MWRITE) begin
            if (mem_addr < 9'h100)         m_ram[mem_addr[7:0]] = write_data;
            else if (mem_addr == ADDR_LED) m_led = write_data[SW_W-1:0];
            else if (mem_addr == ADDR_HEX) m_hex = write_data;
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one command at the falling edge, check the combinational RAM enable, then advance to the next falling edge.
   task automatic applyStimulus(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
      mem_cmd = cmd; mem_addr = addr; write_data = wd;
      #1;
      chk("ram_write", 16'(ram_write), 16'(cmd == MWRITE && addr < 9'h100));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput();
      if (m_rd_valid) chk("read_data", read_data, m_rd);
      chk("ledr", 16'(ledr), 16'(m_led));
      chk("hex0", 16'(hex0), 16'(seg7[m_hex[3:0]]));
      chk("hex1", 16'(hex1), 16'(seg7[m_hex[7:4]]));
      chk("hex2", 16'(hex2), 16'(seg7[m_hex[11:8]]));
      chk("hex3", 16'(hex3), 16'(seg7[m_hex[15:12]]));
   endtask

   task automatic doReset();
      @(negedge clk);
      mem_cmd = MNONE; mem_addr = '0; write_data = '0; sw_in = '0;
      reset = 1'b1;
      clearModel();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  cmd;
      logic [8:0]  addr;
      logic [15:0] wd;
      bit          chk_rd;
      logic [15:0] exp_rd;
      logic [7:0]  exp_led;
   } vec_t;

   vec_t vecs [13];

   initial begin
      logic [7:0] bounce [10];
      logic [8:0] a;
      logic [1:0] c;
      bounce = '{8'h10, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB};

      vecs[0]  = '{MWRITE, ADDR_LED,       16'hABCD, 0, 16'h0000, 8'hCD};
      vecs[1]  = '{MREAD,  ADDR_LED,       16'h0000, 1, 16'h00CD, 8'hCD};
      vecs[2]  = '{MWRITE, ADDR_HEX,       16'h8F30, 0, 16'h0000, 8'hCD};
      vecs[3]  = '{MREAD,  ADDR_HEX,       16'h0000, 1, 16'h8F30, 8'hCD};
      vecs[4]  = '{MREAD,  9'h1FF,         16'h0000, 1, 16'h0000, 8'hCD};
      vecs[5]  = '{MWRITE, ADDR_SW,        16'hFFFF, 0, 16'h0000, 8'hCD};
      vecs[6]  = '{MREAD,  ADDR_SW,        16'h0000, 1, 16'h0000, 8'hCD};
      vecs[7]  = '{MWRITE, 9'h010,         16'h1234, 0, 16'h0000, 8'hCD};
      vecs[8]  = '{MREAD,  9'h010,         16'h0000, 1, 16'h1234, 8'hCD};
      vecs[9]  = '{MWRITE, 9'h1FF,         16'hFFFF, 0, 16'h0000, 8'hCD};
      vecs[10] = '{MREAD,  ADDR_LED,       16'h0000, 1, 16'h00CD, 8'hCD};
      vecs[11] = '{MWRITE, ADDR_LED,       16'h0055, 0, 16'h0000, 8'h55};
      vecs[12] = '{MREAD,  ADDR_LED,       16'h0000, 1, 16'h0055, 8'h55};

      reset = 1'b0;
      doReset();

      // Directed vector table.
      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].cmd, vecs[i].addr, vecs[i].wd);
         if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), read_data, vecs[i].exp_rd);
         chk($sformatf("vec%0d_led", i), 16'(ledr), 16'(vecs[i].exp_led));
         checkOutput();
      end
      chk("hex0_8F30", 16'(hex0), 16'(7'b1000000));
      chk("hex1_8F30", 16'(hex1), 16'(7'b0110000));
      chk("hex2_8F30", 16'(hex2), 16'(7'b0001110));
      chk("hex3_8F30", 16'(hex3), 16'(7'b0000000));

      // Reset in the middle of a cycle clears everything immediately.
      mem_cmd = MNONE;
      @(posedge clk);
      #2 reset = 1'b1;
      clearModel();
      #1;
      chk("rst_read_data", read_data, 16'h0000);
      chk("rst_ledr", 16'(ledr), 16'h0000);
      chk("rst_hex0", 16'(hex0), 16'(7'b1000000));
      chk("rst_hex3", 16'(hex3), 16'(7'b1000000));
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Held switch value is accepted at the seventh edge.
      sw_in = 8'h01;
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(MREAD, ADDR_SW, 16'h0000);
         chk($sformatf("sw_latency_e%0d", k), read_data, (k >= 8) ? 16'h0001 : 16'h0000);
         checkOutput();
      end
      applyStimulus(MREAD, ADDR_SW_STATUS, 16'h0000);
      chk("status_first", read_data, 16'h0001);
      applyStimulus(MREAD, ADDR_SW_STATUS, 16'h0000);
      chk("status_second", read_data, 16'h0000);

      // Bouncing switches never commit an intermediate value.
      for (int v = 0; v < 10; v++) begin
         sw_in = bounce[v];
         for (int k = 0; k < 2; k++) begin
            applyStimulus(MREAD, ADDR_SW, 16'h0000);
            chk("bounce_hold", read_data, 16'h0001);
            checkOutput();
         end
      end
      sw_in = 8'h05;
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(MREAD, ADDR_SW, 16'h0000);
         chk($sformatf("bounce_settle_e%0d", k), read_data, (k >= 8) ? 16'h0005 : 16'h0001);
         checkOutput();
      end
      applyStimulus(MREAD, ADDR_SW_STATUS, 16'h0000);
      chk("bounce_status", read_data, 16'h0001);

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 5))
            0:       a = 9'($urandom_range(0, 255));
            1:       a = ADDR_LED;
            2:       a = ADDR_HEX;
            3:       a = ADDR_SW;
            4:       a = ADDR_SW_STATUS;
            default: a = 9'h180 + 9'($urandom_range(0, 127));
         endcase
         c = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 11) == 0) sw_in = 8'($urandom);
         applyStimulus(c, a, 16'($urandom));
         checkOutput();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mmio_bus_unit.md
# mmio_bus_unit

Memory-mapped I/O and memory-select stage directly downstream of the CPU's memory interface in the lab7 top level. It decodes each CPU memory command, steers reads and writes to the RAM or the board I/O registers, and returns read data with the same one-cycle latency as the RAM. The board I/O is switch input (synchronised and debounced, with a sticky change flag), an LED output register, and a 16-bit hex-display register driving four seven-segment digits.

## Interface
- `SW_W`, 8: switch/LED width, 1..16.
- `DEB_CYCLES`, 4: consecutive stable cycles needed to accept a switch value, ≥2.
- `clk` in 1: system clock (rising edge).
- `reset` in 1: asynchronous, active-high reset.
- `mem_cmd` in 2: memory command; MNONE=00, MREAD=01, MWRITE=10. Code 11 is treated as MNONE.
- `mem_addr` in 9: word address.
- `write_data` in 16: CPU write data.
- `read_data` out 16: registered read data.
- `ram_rdata` in 16: RAM synchronous-read output.
- `ram_write` out 1: RAM write enable (combinational).
- `sw_in` in SW_W: raw board switches (asynchronous).
- `ledr` out SW_W: LED register.
- `hex0`..`hex3` out 7 each: active-low segments (g..a) for nibbles 3:0, 7:4, 11:8, 15:12 of the hex register.

## Operation
- **Address map:**
  - 0x000–0x0FF: RAM.
  - 0x100: LED (R/W).
  - 0x120: HEX (R/W).
  - 0x140: SW (RO).
  - 0x141: SW_STATUS (RO). Bit 0 is the change flag; other bits read 0.
  - All other addresses are unmapped.
- **Writes.**
  - `ram_write` = (mem_cmd==MWRITE) && mem_addr[8]==0.
  - An MWRITE to LED stores write_data[SW_W-1:0] at the edge.
  - An MWRITE to HEX stores all 16 bits.
  - Writes to SW, SW_STATUS and unmapped addresses have no effect.
- **Reads.** For an MREAD, read_data is loaded at the edge as follows:
  - RAM address: ram_rdata, passed through on the next cycle (see Timing).
  - I/O address: the register value, zero-extended.
  - Unmapped address: 0.
  - read_data holds its value whenever mem_cmd≠MREAD.
- **Switch path.**
  - Two-flop synchroniser feeds `cand`; counter `cnt` counts stable cycles.
  - Each edge:
    - If sync≠cand: cand←sync, cnt←0.
    - Else if cnt==DEB_CYCLES-1: stable←cand. If cand≠stable, set the change flag.
    - Else cnt←cnt+1.
  - SW reads return `stable`.
- **Change flag.** A completed MREAD of SW_STATUS clears the flag at that edge. If a set and a clear happen on the same edge, set wins.
- **Hex digits.** Each digit is a combinational decode of 0–F to active-low segments. Example: 0→1000000, 8→0000000, F→0001110.

## Timing
- **Reset values:**
  - read_data=0, ledr=0, HEX reg=0 (all digits show 1000000).
  - stable=0, cand=0, cnt=0, flag=0, synchronisers=0.
- Reset acts immediately, including in the middle of a debounce; the debounce restarts from 0 afterwards.
- I/O read latency is one cycle: command at edge N, data valid after edge N until the next MREAD.
- RAM read: the RAM registers the address at edge N. ram_rdata is valid during cycle N+1 and passes to read_data; the unit registers which source was selected at edge N, so the address need not be held.
- Write-then-read of the same register on consecutive cycles returns the new value.
- Switch latency: a sw_in change that is held steady is committed to `stable` at the (DEB_CYCLES+3)th rising edge after it arrives (edge 7 for DEB_CYCLES=4). Any bounce restarts the count.
- ledr and hex change on the edge of the write.

## Structure
- Package `mmio_pkg`:
  - mem_cmd enum (MNONE/MREAD/MWRITE).
  - Address constants ADDR_LED, ADDR_HEX, ADDR_SW, ADDR_SW_STATUS.
  - Function `hex7seg(nibble)`.
- Sub-module `sw_debouncer` (parameters SW_W, DEB_CYCLES): synchroniser, cand/cnt/stable, and a one-cycle `changed` pulse. The top level holds the sticky flag, the registers and the read mux.

## Test plan
- Reset asserted mid-cycle → all outputs read 0 immediately; hex0..3 = 1000000.
- MWRITE 0x100 with 16'hABCD, then MREAD 0x100 → ledr=8'hCD; read_data=16'h00CD one cycle after the read.
- MWRITE 0x120 with 16'h8F30 → hex0=1000000, hex1=0110000, hex2=0001110, hex3=0000000.
- sw_in=8'h01 held steady → SW reads 0 until edge 7, then 1; SW_STATUS reads 1, and a second SW_STATUS read returns 0.
- sw_in toggles every 2 cycles for 20 cycles, then holds 8'h05 → stable never takes an intermediate value and ends at 8'h05 seven edges after the last toggle.
- MWRITE to 0x010 → ram_write=1. MWRITE 0x140 → SW unchanged. MREAD 0x1FF → read_data=0.
